// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Lookup, resolve and statistics signals between the core
//               (master) and the branch predictor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int WIDTH      = 32,
    parameter int GHIST_BITS = 0,
    parameter int STAT_BITS  = 16
);
    localparam int c_HIST_W = (GHIST_BITS > 0) ? GHIST_BITS : 1;

    // Fetch-stage lookup
    logic [WIDTH-1:0]    pc_f;
    logic                pred_taken_f;
    logic [WIDTH-1:0]    pred_target_f;
    logic [c_HIST_W-1:0] ghist_f;

    // Decode-stage resolution
    logic                upd_en;
    logic [WIDTH-1:0]    upd_pc;
    logic [c_HIST_W-1:0] upd_ghist;
    logic                upd_taken;
    logic [WIDTH-1:0]    upd_target;
    logic                upd_pred_taken;
    logic [WIDTH-1:0]    upd_pred_target;
    logic                mispredict_d;

    // Statistics
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    modport master (
        output pc_f, upd_en, upd_pc, upd_ghist, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken_f, pred_target_f, ghist_f, mispredict_d,
               branch_count, mispredict_count
    );

    modport slave (
        input  pc_f, upd_en, upd_pc, upd_ghist, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken_f, pred_target_f, ghist_f, mispredict_d,
               branch_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Tagged direct-mapped BTB with saturating-counter PHT;
//               bimodal when GHIST_BITS=0, gshare otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int WIDTH      = 32,
    parameter int IDX_BITS   = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int GHIST_BITS = 0,
    parameter int STAT_BITS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int c_ENTRIES = 1 << IDX_BITS;
    localparam int c_HIST_W  = (GHIST_BITS > 0) ? GHIST_BITS : 1;
    localparam int c_TAG_LSB = IDX_BITS + 2;

    localparam logic [CTR_BITS-1:0] c_CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] c_CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] c_CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [STAT_BITS-1:0] c_STAT_MAX = {STAT_BITS{1'b1}};

    // Table storage
    logic                r_valid  [c_ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [c_ENTRIES];
    logic [WIDTH-1:0]    r_target [c_ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [c_ENTRIES];

    logic [c_HIST_W-1:0]  w_ghist;
    logic [IDX_BITS-1:0]  w_lk_idx;
    logic [IDX_BITS-1:0]  w_up_idx;
    logic [TAG_BITS-1:0]  w_lk_tag;
    logic [TAG_BITS-1:0]  w_up_tag;
    logic                 w_lk_hit;
    logic                 w_up_hit;
    logic [CTR_BITS-1:0]  w_up_ctr;
    logic                 w_mispredict;
    logic [STAT_BITS-1:0] r_branch_count;
    logic [STAT_BITS-1:0] r_mispredict_count;

    // Bits of the PCs outside the index/tag fields are intentionally ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{bp.pc_f, bp.upd_pc, bp.upd_ghist};

    // Global history is non-speculative: it only shifts on resolved branches.
    if (GHIST_BITS > 1) begin : g_hist_multi
        logic [GHIST_BITS-1:0] r_ghist;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ghist <= '0;
            end else if (bp.upd_en) begin
                r_ghist <= {r_ghist[GHIST_BITS-2:0], bp.upd_taken};
            end
        end
        assign w_ghist = r_ghist;
    end else if (GHIST_BITS == 1) begin : g_hist_single
        logic r_ghist;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ghist <= 1'b0;
            end else if (bp.upd_en) begin
                r_ghist <= bp.upd_taken;
            end
        end
        assign w_ghist = r_ghist;
    end else begin : g_hist_none
        assign w_ghist = '0;
    end

    if (GHIST_BITS > 0) begin : g_idx_gshare
        assign w_lk_idx = bp.pc_f[IDX_BITS+1:2]   ^ IDX_BITS'(w_ghist);
        assign w_up_idx = bp.upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.upd_ghist);
    end else begin : g_idx_bimodal
        assign w_lk_idx = bp.pc_f[IDX_BITS+1:2];
        assign w_up_idx = bp.upd_pc[IDX_BITS+1:2];
    end

    assign w_lk_tag = bp.pc_f[c_TAG_LSB +: TAG_BITS];
    assign w_up_tag = bp.upd_pc[c_TAG_LSB +: TAG_BITS];

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign w_lk_hit         = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign bp.pred_taken_f  = w_lk_hit & r_ctr[w_lk_idx][CTR_BITS-1];
    assign bp.pred_target_f = w_lk_hit ? r_target[w_lk_idx] : '0;
    assign bp.ghist_f       = w_ghist;

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_WNT;
            end
        end else if (bp.upd_en) begin
            if (w_up_hit) begin
                if (bp.upd_taken) begin
                    r_target[w_up_idx] <= bp.upd_target;
                    if (w_up_ctr != c_CTR_MAX) begin
                        r_ctr[w_up_idx] <= w_up_ctr + CTR_BITS'(1);
                    end
                end else if (w_up_ctr != '0) begin
                    r_ctr[w_up_idx] <= w_up_ctr - CTR_BITS'(1);
                end
            end else if (bp.upd_taken) begin
                // Taken miss evicts whatever occupies the slot.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.upd_target;
                r_ctr[w_up_idx]    <= c_CTR_WT;
            end
        end
    end

    assign w_mispredict = bp.upd_en &
                          ((bp.upd_taken != bp.upd_pred_taken) |
                           (bp.upd_taken & bp.upd_pred_taken &
                            (bp.upd_target != bp.upd_pred_target)));
    assign bp.mispredict_d = w_mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (bp.upd_en && (r_branch_count != c_STAT_MAX)) begin
                r_branch_count <= r_branch_count + STAT_BITS'(1);
            end
            if (w_mispredict && (r_mispredict_count != c_STAT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + STAT_BITS'(1);
            end
        end
    end

    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed checks of bimodal, gshare and narrow-statistics
//               predictor configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    branch_predictor_if #(.WIDTH(32), .GHIST_BITS(0), .STAT_BITS(16)) bm_if ();
    branch_predictor_if #(.WIDTH(32), .GHIST_BITS(4), .STAT_BITS(16)) gs_if ();
    branch_predictor_if #(.WIDTH(32), .GHIST_BITS(0), .STAT_BITS(2))  st_if ();

    branch_predictor #(.WIDTH(32), .IDX_BITS(6), .TAG_BITS(8), .CTR_BITS(2),
                       .GHIST_BITS(0), .STAT_BITS(16)) u_bm (
        .clk(clk), .reset(reset), .bp(bm_if.slave));
    branch_predictor #(.WIDTH(32), .IDX_BITS(6), .TAG_BITS(8), .CTR_BITS(2),
                       .GHIST_BITS(4), .STAT_BITS(16)) u_gs (
        .clk(clk), .reset(reset), .bp(gs_if.slave));
    branch_predictor #(.WIDTH(32), .IDX_BITS(6), .TAG_BITS(8), .CTR_BITS(2),
                       .GHIST_BITS(0), .STAT_BITS(2)) u_st (
        .clk(clk), .reset(reset), .bp(st_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bm_if.upd_en = 1'b0;
        gs_if.upd_en = 1'b0;
        st_if.upd_en = 1'b0;
        #1;
    endtask

    task automatic bm_drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        bm_if.upd_en = 1'b1; bm_if.upd_pc = pc; bm_if.upd_taken = tk;
        bm_if.upd_target = tgt; bm_if.upd_pred_taken = ptk; bm_if.upd_pred_target = ptgt;
        #1;
    endtask

    task automatic gs_drive(input logic [31:0] pc, input logic [3:0] gh, input logic tk,
                            input logic [31:0] tgt);
        gs_if.upd_en = 1'b1; gs_if.upd_pc = pc; gs_if.upd_ghist = gh; gs_if.upd_taken = tk;
        gs_if.upd_target = tgt; gs_if.upd_pred_taken = 1'b0; gs_if.upd_pred_target = 32'h0;
        #1;
    endtask

    task automatic st_drive(input logic [31:0] pc, input logic tk);
        st_if.upd_en = 1'b1; st_if.upd_pc = pc; st_if.upd_ghist = 1'b0; st_if.upd_taken = tk;
        st_if.upd_target = 32'h0040_0400; st_if.upd_pred_taken = 1'b0;
        st_if.upd_pred_target = 32'h0;
        #1;
    endtask

    // Training step on the bimodal instance, then the prediction that follows it.
    task automatic bm_train(input string tag, input logic tk, input logic ptk,
                            input logic exp_pred);
        bm_drive(32'h0040_0010, tk, 32'h0040_0040, ptk, 32'h0040_0040);
        tick();
        bm_if.pc_f = 32'h0040_0010;
        #1;
        chk(tag, 32'(bm_if.pred_taken_f), 32'(exp_pred));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bm_if.pc_f = '0; bm_if.upd_en = 0; bm_if.upd_pc = '0; bm_if.upd_ghist = '0;
        bm_if.upd_taken = 0; bm_if.upd_target = '0; bm_if.upd_pred_taken = 0;
        bm_if.upd_pred_target = '0;
        gs_if.pc_f = '0; gs_if.upd_en = 0; gs_if.upd_pc = '0; gs_if.upd_ghist = '0;
        gs_if.upd_taken = 0; gs_if.upd_target = '0; gs_if.upd_pred_taken = 0;
        gs_if.upd_pred_target = '0;
        st_if.pc_f = '0; st_if.upd_en = 0; st_if.upd_pc = '0; st_if.upd_ghist = '0;
        st_if.upd_taken = 0; st_if.upd_target = '0; st_if.upd_pred_taken = 0;
        st_if.upd_pred_target = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        bm_if.pc_f = 32'h0040_0010;
        #1;
        chk("rst_pred_taken", 32'(bm_if.pred_taken_f), 32'd0);
        chk("rst_pred_target", bm_if.pred_target_f, 32'd0);
        chk("rst_branch_count", 32'(bm_if.branch_count), 32'd0);
        chk("rst_mispredict_count", 32'(bm_if.mispredict_count), 32'd0);
        chk("rst_gs_ghist", 32'(gs_if.ghist_f), 32'd0);

        // upd_* ignored while upd_en is low
        bm_drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        bm_if.upd_en = 1'b0;
        #1;
        chk("idle_mispredict", 32'(bm_if.mispredict_d), 32'd0);
        tick();
        chk("idle_no_alloc", 32'(bm_if.pred_taken_f), 32'd0);
        chk("idle_branch_count", 32'(bm_if.branch_count), 32'd0);

        // Allocation; lookup in the same cycle still sees the old entry
        bm_drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        chk("alloc_mispredict", 32'(bm_if.mispredict_d), 32'd1);
        chk("alloc_no_bypass", 32'(bm_if.pred_taken_f), 32'd0);
        tick();
        chk("alloc_pred_taken", 32'(bm_if.pred_taken_f), 32'd1);
        chk("alloc_pred_target", bm_if.pred_target_f, 32'h0040_0040);
        chk("alloc_branch_count", 32'(bm_if.branch_count), 32'd1);
        chk("alloc_mispredict_count", 32'(bm_if.mispredict_count), 32'd1);

        // Same index, different tag misses
        bm_if.pc_f = 32'h0040_0110;
        #1;
        chk("alias_lookup_taken", 32'(bm_if.pred_taken_f), 32'd0);
        chk("alias_lookup_target", bm_if.pred_target_f, 32'd0);

        // Counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3
        bm_train("ctr_2to1", 1'b0, 1'b1, 1'b0);
        bm_train("ctr_1to0", 1'b0, 1'b0, 1'b0);
        bm_train("ctr_floor", 1'b0, 1'b0, 1'b0);
        bm_train("ctr_0to1", 1'b1, 1'b0, 1'b0);
        bm_train("ctr_1to2", 1'b1, 1'b0, 1'b1);
        bm_drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
        chk("correct_no_mispredict", 32'(bm_if.mispredict_d), 32'd0);
        tick();
        // Taken at ctr=3 with a wrong predicted target
        bm_drive(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0044);
        chk("target_mispredict", 32'(bm_if.mispredict_d), 32'd1);
        tick();
        bm_if.pc_f = 32'h0040_0010;
        #1;
        chk("target_retrained", bm_if.pred_target_f, 32'h0040_0080);
        // Cap check: from 3 two not-takens give 2 (taken) then 1 (not taken)
        bm_drive(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0080);
        tick();
        chk("ctr_cap_3to2", 32'(bm_if.pred_taken_f), 32'd1);
        bm_drive(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0080);
        tick();
        chk("ctr_2to1_again", 32'(bm_if.pred_taken_f), 32'd0);
        chk("train_branch_count", 32'(bm_if.branch_count), 32'd10);
        chk("train_mispredict_count", 32'(bm_if.mispredict_count), 32'd7);

        // Aliasing replacement
        bm_drive(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        tick();
        bm_if.pc_f = 32'h0040_0110;
        #1;
        chk("replace_new_taken", 32'(bm_if.pred_taken_f), 32'd1);
        chk("replace_new_target", bm_if.pred_target_f, 32'h0040_0200);
        bm_if.pc_f = 32'h0040_0010;
        #1;
        chk("replace_old_miss", 32'(bm_if.pred_taken_f), 32'd0);
        chk("replace_old_target", bm_if.pred_target_f, 32'd0);
        // Not-taken miss leaves the occupant alone
        bm_drive(32'h0040_0210, 1'b0, 32'h0040_0300, 1'b0, 32'h0);
        tick();
        bm_if.pc_f = 32'h0040_0110;
        #1;
        chk("nt_miss_keeps", bm_if.pred_target_f, 32'h0040_0200);
        chk("nt_miss_branch_count", 32'(bm_if.branch_count), 32'd12);
        chk("nt_miss_mispredict_count", 32'(bm_if.mispredict_count), 32'd8);

        // Gshare history: T,T,NT,T
        gs_drive(32'h0040_0020, 4'h0, 1'b1, 32'h0040_0100); tick();
        gs_drive(32'h0040_0020, 4'h0, 1'b1, 32'h0040_0100); tick();
        chk("gs_ghist_0011", 32'(gs_if.ghist_f), 32'h3);
        gs_drive(32'h0040_0020, 4'h0, 1'b0, 32'h0); tick();
        gs_drive(32'h0040_0020, 4'h0, 1'b1, 32'h0040_0100); tick();
        chk("gs_ghist_1101", 32'(gs_if.ghist_f), 32'hD);
        // Trains idx 4^D = 9; history becomes 1011
        gs_drive(32'h0040_0010, 4'hD, 1'b1, 32'h0040_0300); tick();
        chk("gs_ghist_1011", 32'(gs_if.ghist_f), 32'hB);
        gs_if.pc_f = 32'h0040_0008;  // idx 2 ^ B = 9, tag 0
        #1;
        chk("gs_hashed_hit", 32'(gs_if.pred_taken_f), 32'd1);
        chk("gs_hashed_target", gs_if.pred_target_f, 32'h0040_0300);
        for (int i = 0; i < 4; i++) begin
            gs_drive(32'h0040_0080, 4'h0, 1'b0, 32'h0);
            tick();
        end
        chk("gs_ghist_cleared", 32'(gs_if.ghist_f), 32'h0);
        gs_if.pc_f = 32'h0040_0010;
        #1;
        chk("gs_zero_hist_miss", 32'(gs_if.pred_taken_f), 32'd0);
        chk("gs_zero_hist_target", gs_if.pred_target_f, 32'd0);

        // Statistics saturation at 2 bits
        for (int i = 0; i < 3; i++) begin
            st_drive(32'h0040_0040, 1'b1);
            tick();
        end
        chk("st_branch_3", 32'(st_if.branch_count), 32'd3);
        chk("st_mispredict_3", 32'(st_if.mispredict_count), 32'd3);
        for (int i = 0; i < 2; i++) begin
            st_drive(32'h0040_0040, 1'b1);
            tick();
        end
        chk("st_branch_sat", 32'(st_if.branch_count), 32'd3);
        chk("st_mispredict_sat", 32'(st_if.mispredict_count), 32'd3);
        st_if.pc_f = 32'h0040_0040;
        #1;
        chk("st_trained", 32'(st_if.pred_taken_f), 32'd1);

        // Reset wins over a simultaneous update
        reset = 1'b1;
        st_drive(32'h0040_0050, 1'b1);
        chk("rst_mispredict_comb", 32'(st_if.mispredict_d), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_branch_count", 32'(st_if.branch_count), 32'd0);
        chk("rst2_mispredict_count", 32'(st_if.mispredict_count), 32'd0);
        chk("rst2_trained_lost", 32'(st_if.pred_taken_f), 32'd0);
        st_if.pc_f = 32'h0040_0050;
        #1;
        chk("rst2_no_alloc", 32'(st_if.pred_taken_f), 32'd0);
        chk("rst2_gs_ghist", 32'(gs_if.ghist_f), 32'd0);
        bm_if.pc_f = 32'h0040_0110;
        #1;
        chk("rst2_bm_cleared", bm_if.pred_target_f, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS core.
- Combines a direct-mapped, tagged branch target buffer (BTB) with a pattern history table (PHT) of saturating counters.
- Modes: bimodal when GHIST_BITS=0; gshare when GHIST_BITS>0.
- Lookup is combinational on the F-stage PC. Training happens when a branch resolves in D (the stage that drives pc_src_d/eq_d). The block reports mispredicts so the core can redirect and flush.

Parameters:
- WIDTH, 32, PC/target width in bits.
- IDX_BITS, 6, log2 of entry count (64 entries).
- TAG_BITS, 8, stored tag width. Tag = pc[IDX_BITS+TAG_BITS+1 : IDX_BITS+2].
- CTR_BITS, 2, PHT counter width (minimum 1).
- GHIST_BITS, 0, global history length. 0 = bimodal. Must be <= IDX_BITS.
- STAT_BITS, 16, width of the statistics counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- pc_f  input  WIDTH  fetch PC to look up
- pred_taken_f  output  1  predict taken
- pred_target_f  output  WIDTH  predicted target (valid when pred_taken_f=1)
- ghist_f  output  max(GHIST_BITS,1)  current history; core pipelines it to D with the instruction
- upd_en  input  1  a branch resolves this cycle (core gates with ~stall_d)
- upd_pc  input  WIDTH  PC of resolving branch
- upd_ghist  input  max(GHIST_BITS,1)  ghist_f value captured at that branch's fetch
- upd_taken  input  1  actual outcome
- upd_target  input  WIDTH  actual taken target
- upd_pred_taken  input  1  prediction that was made for this branch
- upd_pred_target  input  WIDTH  target that was predicted
- mispredict_d  output  1  resolving branch was mispredicted
- branch_count  output  STAT_BITS  number of resolved branches
- mispredict_count  output  STAT_BITS  number of mispredicts

Behaviour:
- Index computation:
  - Bimodal: idx(pc) = pc[IDX_BITS+1:2].
  - Gshare: idx(pc,h) = pc[IDX_BITS+1:2] XOR zero-extended h.
  - Lookup uses pc_f with the internal ghist. Update uses upd_pc with upd_ghist.
- Entry contents: valid, tag, target, ctr.
- Lookup is purely combinational, zero latency.
  - hit = valid & (tag == tag(pc_f)).
  - pred_taken_f = hit & ctr[CTR_BITS-1].
  - pred_target_f = entry target when hit, else 0.
- Same-cycle lookup and update of the same entry: lookup returns pre-update contents. There is no bypass.
- Update on the rising edge when upd_en=1, at entry e = idx(upd_pc, upd_ghist):
  - Tag hit: ctr saturates up if taken (cap 2^CTR_BITS-1), saturates down if not taken (floor 0). If taken, target <= upd_target.
  - Tag miss, taken: allocate. valid<=1, tag<=tag(upd_pc), target<=upd_target, ctr<=2^(CTR_BITS-1) (weakly taken). Any previous occupant is replaced.
  - Tag miss, not taken: no change to the entry.
- Global history:
  - On upd_en: ghist <= {ghist[GHIST_BITS-2:0], upd_taken}. History is non-speculative.
  - Bimodal mode: ghist held at 0.
- mispredict_d (combinational) = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- Statistics:
  - branch_count increments on each upd_en.
  - mispredict_count increments when mispredict_d=1.
  - Both saturate at 2^STAT_BITS-1 and do not wrap.
- Reset (takes priority over upd_en in the same cycle):
  - All valid<=0.
  - All ctr<=2^(CTR_BITS-1)-1 (weakly not-taken).
  - ghist<=0; both stat counters <=0.
  - Outputs after reset: pred_taken_f=0, pred_target_f=0, ghist_f=0, counts=0.
  - mispredict_d stays combinational from its inputs.
  - Reset mid-run discards all trained state.
- Reset on the table may be a per-entry loop or a valid-bit clear. The observable behaviour must match the above either way.
- X-safety: upd_* inputs are ignored when upd_en=0.

Test Plan:
1. Reset, then pc_f=0x00400010 -> pred_taken_f=0, pred_target_f=0, branch_count=0.
2. Allocate and predict:
   - Stimulus: upd_en with upd_pc=0x00400010, taken, upd_target=0x00400040, upd_pred_taken=0.
   - Same cycle: mispredict_d=1.
   - Next cycle with pc_f=0x00400010: pred_taken_f=1, pred_target_f=0x00400040, ctr=2; branch_count=1, mispredict_count=1.
3. Training and saturation on the same PC:
   - Two not-taken updates -> ctr 2->1->0, pred_taken_f=0 after the first.
   - One more not-taken -> ctr stays 0.
   - Four taken -> ctr 1,2,3,3.
4. Aliasing: pc 0x00400110 (same idx 4, tag 0x01) looked up after scenario 2 -> pred_taken_f=0. A taken update to it replaces the entry, after which 0x00400010 misses.
5. Gshare (GHIST_BITS=4):
   - Updates with taken,taken,not-taken,taken -> ghist_f=4'b1101.
   - A branch updated with upd_ghist=4'b1101 at pc 0x00400010 trains idx 0x04^0x0D=0x09.
   - Lookup at the same pc with ghist 0 does not hit it.
6. Stat saturation and reset mid-run (STAT_BITS=2):
   - Five mispredicting updates -> both counts=3.
   - Assert reset while upd_en=1 -> next cycle counts=0, ghist_f=0, no allocation made.
